// File: rtl/upsample_2x.sv
// upsample_2x: 2x2 nearest-neighbour upsampler for fp16 pixel streams.
// One input row of IMG_W pixels is buffered, then replayed as two output
// rows of 2*IMG_W pixels each, with row-last and frame-last flags.
// Build option: define UPSAMPLE_ZERO_FILL_EN for max-unpooling mode, where
// only the top-left position of each 2x2 block carries the pixel and the
// other three positions are zero. Timing and flags do not change.
module upsample_2x #(
  parameter int IMG_W = 4,
  parameter int IMG_H = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic        out_row_last,
  output logic        out_frame_last
);

  localparam int IW = $clog2(IMG_W);
  localparam int OW = IW + 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  localparam logic [IW-1:0] IC_LAST  = IW'(IMG_W - 1);
  localparam logic [OW-1:0] OC_LAST  = OW'(2 * IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  typedef enum logic {
    LOAD = 1'b0,
    EMIT = 1'b1
  } state_e;

  state_e         state_q;
  logic [IW-1:0]  ic_q;
  logic [OW-1:0]  oc_q;
  logic           rep_q;
  logic [RW-1:0]  row_q;
  logic           in_ready_q;
  logic           out_valid_q;
  logic [15:0]    out_data_q;
  logic           row_last_q;
  logic           frame_last_q;

  logic [15:0]    row_buf_q [IMG_W];

  logic [OW-1:0]  oc_d;
  logic           rep_d;
  logic [15:0]    pix_d;

  logic           in_fire;
  logic           out_fire;

  assign in_fire  = in_valid && in_ready_q;
  assign out_fire = out_valid_q && out_ready;

  assign in_ready       = in_ready_q;
  assign out_valid      = out_valid_q;
  assign out_data       = out_data_q;
  assign out_row_last   = row_last_q;
  assign out_frame_last = frame_last_q;

  // Row buffer: written only while loading; never read before it is refilled.
  // NOTE: storage arrays carry no reset; the FSM guarantees every entry is
  // rewritten before it is read, so a reset would only add fan-out.
  always_ff @(posedge clk) begin
    if (state_q == LOAD && in_fire) begin
      row_buf_q[ic_q] <= in_data;
    end
  end

  // Next output position and the pixel that belongs there.
  // NOTE: every combinational output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    oc_d  = oc_q + 1'b1;
    rep_d = rep_q;
    if (oc_q == OC_LAST) begin
      oc_d  = '0;
      rep_d = ~rep_q;
    end
    pix_d = row_buf_q[oc_d[OW-1:1]];
`ifdef UPSAMPLE_ZERO_FILL_EN
    if (rep_d || oc_d[0]) begin
      pix_d = 16'h0000;
    end
`endif
  end

  // Control FSM with registered handshake, data and flag outputs.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register sees the pre-edge values of the others.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= LOAD;
      ic_q         <= '0;
      oc_q         <= '0;
      rep_q        <= 1'b0;
      row_q        <= '0;
      in_ready_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= 16'h0000;
      row_last_q   <= 1'b0;
      frame_last_q <= 1'b0;
    end else begin
      case (state_q)
        LOAD: begin
          in_ready_q <= 1'b1;
          if (in_fire) begin
            if (ic_q == IC_LAST) begin
              // Row complete: first output beat is column 0, repeat 0.
              ic_q         <= '0;
              state_q      <= EMIT;
              in_ready_q   <= 1'b0;
              out_valid_q  <= 1'b1;
              oc_q         <= '0;
              rep_q        <= 1'b0;
              out_data_q   <= row_buf_q[0];
              row_last_q   <= 1'b0;
              frame_last_q <= 1'b0;
            end else begin
              ic_q <= ic_q + 1'b1;
            end
          end
        end
        EMIT: begin
          if (out_fire) begin
            if (oc_q == OC_LAST && rep_q) begin
              // Second copy of the row is out: back to loading.
              state_q      <= LOAD;
              in_ready_q   <= 1'b1;
              out_valid_q  <= 1'b0;
              oc_q         <= '0;
              rep_q        <= 1'b0;
              out_data_q   <= 16'h0000;
              row_last_q   <= 1'b0;
              frame_last_q <= 1'b0;
              row_q        <= (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
            end else begin
              oc_q         <= oc_d;
              rep_q        <= rep_d;
              out_data_q   <= pix_d;
              row_last_q   <= (oc_d == OC_LAST);
              frame_last_q <= (oc_d == OC_LAST) && rep_d && (row_q == ROW_LAST);
            end
          end
        end
        default: begin
          state_q <= LOAD;
        end
      endcase
    end
  end

endmodule
